// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/DIV sequencer (shift-add multiply, restoring divide) with HI/LO result registers.
// Define MULDIV_SIGNED_EN for two's-complement operands; the default build is unsigned.
module muldiv_sequencer #(
  parameter int         WIDTH   = 32,
  parameter logic [3:0] OP_MULT = 4'd6,
  parameter logic [3:0] OP_DIV  = 4'd7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_a_raw;
  logic               r_is_div;
  logic               r_dz;
`ifdef MULDIV_SIGNED_EN
  logic               r_neg_res;
  logic               r_neg_rem;
`endif

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH-1:0]   w_div_diff;
  logic               w_div_ge;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0]   w_hi_res;
  logic [WIDTH-1:0]   w_lo_res;
  logic               w_accept;

`ifdef MULDIV_SIGNED_EN
  assign w_mag_a = op_a[WIDTH-1] ? -op_a : op_a;
  assign w_mag_b = op_b[WIDTH-1] ? -op_b : op_b;
`else
  assign w_mag_a = op_a;
  assign w_mag_b = op_b;
`endif

  assign w_accept = start && !flush && ((alu_op == OP_MULT) || (alu_op == OP_DIV));

  // r_acc holds {partial product, multiplier} for MULT and {remainder, dividend/quotient} for DIV.
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    w_div_diff  = w_div_shift[WIDTH-1:0] - r_opnd;
    if (r_is_div)
      w_acc_next = {(w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0]), r_acc[WIDTH-2:0], w_div_ge};
    else
      w_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};
  end

  always_comb begin
    w_hi_res = w_acc_next[2*WIDTH-1:WIDTH];
    w_lo_res = w_acc_next[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
    if (r_is_div) begin
      if (r_neg_res) w_lo_res = -w_acc_next[WIDTH-1:0];
      if (r_neg_rem) w_hi_res = -w_acc_next[2*WIDTH-1:WIDTH];
    end else if (r_neg_res) begin
      {w_hi_res, w_lo_res} = -w_acc_next;
    end
`endif
    if (r_is_div && r_dz) begin
      w_hi_res = r_a_raw;
      w_lo_res = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_a_raw   <= '0;
      r_is_div  <= 1'b0;
      r_dz      <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state   <= S_RUN;
            r_busy    <= 1'b1;
            r_cnt     <= '0;
            r_is_div  <= (alu_op == OP_DIV);
            r_acc     <= {{WIDTH{1'b0}}, (alu_op == OP_DIV) ? w_mag_a : w_mag_b};
            r_opnd    <= (alu_op == OP_DIV) ? w_mag_b : w_mag_a;
            r_a_raw   <= op_a;
            r_dz      <= (op_b == '0);
`ifdef MULDIV_SIGNED_EN
            r_neg_res <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            r_neg_rem <= op_a[WIDTH-1];
`endif
          end
        end
        S_RUN: begin
          if (flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_hi    <= w_hi_res;
              r_lo    <= w_lo_res;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer; expected {hi,lo} results go through a scoreboard queue.
module tb_muldiv_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  alu_op = 4'd0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int nchk = 0;
  int nerr = 0;
  logic [63:0] sb_q[$];
  logic [63:0] prev;
  int          ndone;

  localparam logic [3:0] MULT = 4'd6;
  localparam logic [3:0] DIV  = 4'd7;

  muldiv_sequencer #(.WIDTH(32), .OP_MULT(4'd6), .OP_DIV(4'd7)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_op(alu_op),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; alu_op = op; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0;
    $display("launch op=%0d a=%h b=%h", op, a, b);
  endtask

  // Called at the negedge cyc0 cycles after the start-sampling edge.
  task automatic finish_op(input string tag, input int cyc0);
    int cyc;
    int nb;
    logic [63:0] e;
    cyc = cyc0;
    nb  = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (busy === 1'b1) nb++;
      @(negedge clk);
      cyc++;
    end
    if (busy === 1'b1) nb++;
    check({tag, "_latency"}, 64'(cyc), 64'd32);
    check({tag, "_busy_cycles"}, 64'(nb), 64'(33 - cyc0));
    if (sb_q.size() > 0) e = sb_q.pop_front();
    else e = 'x;
    check({tag, "_result"}, {hi, lo}, e);
    $display("%s: hi=%h lo=%h latency=%0d", tag, hi, lo, cyc);
    @(negedge clk);
    check({tag, "_done_width"}, {63'd0, done}, 64'd0);
    check({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #12;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    sb_q.push_back(64'h0000_0001_0000_0000);
    launch(MULT, 32'h0001_0000, 32'h0001_0000);
    finish_op("mult_2p16", 0);

    sb_q.push_back({32'd2, 32'd14});
    launch(DIV, 32'd100, 32'd7);
    finish_op("div_100_7", 0);

    sb_q.push_back({32'd5, 32'hFFFF_FFFF});
    launch(DIV, 32'd5, 32'd0);
    finish_op("div_by_zero", 0);

`ifdef MULDIV_SIGNED_EN
    sb_q.push_back(64'hFFFF_FFFF_FFFF_FFF1);
    launch(MULT, 32'hFFFF_FFFD, 32'd5);
    finish_op("smult_m3_5", 0);

    sb_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    launch(DIV, 32'hFFFF_FFF9, 32'd2);
    finish_op("sdiv_m7_2", 0);
`else
    sb_q.push_back(64'hFFFF_FFFE_0000_0001);
    launch(MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("mult_max", 0);

    sb_q.push_back({32'h0000_000F, 32'h0FFF_FFFF});
    launch(DIV, 32'hFFFF_FFFF, 32'h0000_0010);
    finish_op("div_max_16", 0);
`endif

    // Non-MULT/DIV code must not start anything.
    prev = {hi, lo};
    launch(4'd0, 32'd9, 32'd9);
    check("bad_op_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("bad_op_hilo", {hi, lo}, prev);

    // A second start while busy is dropped, not queued.
    sb_q.push_back({32'd1, 32'd333});
    launch(DIV, 32'd1000, 32'd3);
    repeat (3) @(negedge clk);
    start = 1'b1; alu_op = MULT; op_a = 32'd2; op_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    finish_op("div_start_while_busy", 4);
    @(negedge clk);
    check("no_queued_op", {63'd0, busy}, 64'd0);

    // Flush in RUN aborts without a done pulse or result change.
    prev = {hi, lo};
    launch(MULT, 32'd7, 32'd9);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("flush_no_done", 64'(ndone), 64'd0);
    check("flush_hilo", {hi, lo}, prev);
    $display("flush: hi=%h lo=%h done_pulses=%0d", hi, lo, ndone);

    // Flush together with start in IDLE drops the request.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; alu_op = MULT; op_a = 32'd3; op_b = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_idle_busy", {63'd0, busy}, 64'd0);

    // Asynchronous reset in the middle of an operation.
    launch(MULT, 32'd11, 32'd13);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset_busy", {63'd0, busy}, 64'd0);
    check("midrun_reset_done", {63'd0, done}, 64'd0);
    check("midrun_reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_reset_idle", {63'd0, busy}, 64'd0);

    sb_q.push_back({32'd2, 32'd14});
    launch(DIV, 32'd100, 32'd7);
    finish_op("div_after_reset", 0);

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
